// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bus bundle between two cache-line requesters, the arbiter and one memory.
//
// Requester side (per port x in {0,1}):
//   mx_enable_i  request, held for the whole transaction sequence
//   mx_write_i   1 = write, 0 = read
//   mx_addr_i    32-bit line address
//   mx_data_i    256-bit write line
//   mx_ack_o     memory acknowledge, seen only by the owning port
//   mx_data_o    256-bit read line, 0 on the non-owning port
// Memory side:
//   mem_enable_o, mem_write_o, mem_addr_o, mem_data_o  request to memory
//   mem_data_i, mem_ack_i                             response from memory
//
// Modports:
//   slave  - the arbiter's view (requests in, responses out)
//   master - the environment's view (requesters and memory model)
// -----------------------------------------------------------------------------
interface mem_arbiter_if;
  logic         m0_enable_i;
  logic         m1_enable_i;
  logic         m0_write_i;
  logic         m1_write_i;
  logic [31:0]  m0_addr_i;
  logic [31:0]  m1_addr_i;
  logic [255:0] m0_data_i;
  logic [255:0] m1_data_i;
  logic         m0_ack_o;
  logic         m1_ack_o;
  logic [255:0] m0_data_o;
  logic [255:0] m1_data_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  m0_enable_i, m1_enable_i,
    input  m0_write_i,  m1_write_i,
    input  m0_addr_i,   m1_addr_i,
    input  m0_data_i,   m1_data_i,
    output m0_ack_o,    m1_ack_o,
    output m0_data_o,   m1_data_o,
    output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    input  mem_data_i,  mem_ack_i
  );

  modport master (
    output m0_enable_i, m1_enable_i,
    output m0_write_i,  m1_write_i,
    output m0_addr_i,   m1_addr_i,
    output m0_data_i,   m1_data_i,
    input  m0_ack_o,    m1_ack_o,
    input  m0_data_o,   m1_data_o,
    input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
    output mem_data_i,  mem_ack_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-port arbiter in front of a single line-wide memory. A grant covers the
// whole time a requester holds its enable, so a writeback followed by a refill
// goes out as one uninterrupted ownership period. Ties are broken against the
// port that owned last. Between two owners the memory always sees its enable
// low for at least two cycles (owner's drop cycle plus a one-cycle gap).
//
// Ports:
//   clk_i       rising-edge clock
//   rst_i       asynchronous, active-low reset
//   bus         mem_arbiter_if.slave - requester and memory signals
//   ack_cnt0_o  acks delivered to port 0 (wraps modulo 2^CNT_W)
//   ack_cnt1_o  acks delivered to port 1 (wraps modulo 2^CNT_W)
//   err_o       sticky: an ack arrived while no port owned the memory
//
// Parameters:
//   CNT_W       width of the per-port ack counters
// -----------------------------------------------------------------------------
module mem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  mem_arbiter_if.slave     bus,
  output logic [CNT_W-1:0] ack_cnt0_o,
  output logic [CNT_W-1:0] ack_cnt1_o,
  output logic             err_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    GAP  = 2'd3
  } state_e;

  state_e           state_q;
  state_e           state_d;
  // last_q names the port that owned most recently; 1 after reset so that
  // port 0 wins the first tie.
  logic             last_q;
  logic             last_d;
  logic [CNT_W-1:0] cnt0_q;
  logic [CNT_W-1:0] cnt0_d;
  logic [CNT_W-1:0] cnt1_q;
  logic [CNT_W-1:0] cnt1_d;
  logic             err_q;
  logic             err_d;

  // State, tie pointer, counters and error flag registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt0_q  <= '0;
      cnt1_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt0_q  <= cnt0_d;
      cnt1_q  <= cnt1_d;
      err_q   <= err_d;
    end
  end

  // Ownership FSM next state and tie pointer update.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (bus.m0_enable_i && bus.m1_enable_i) begin
          // Both pending: favour whoever did not own last.
          state_d = last_q ? OWN0 : OWN1;
        end else if (bus.m0_enable_i) begin
          state_d = OWN0;
        end else if (bus.m1_enable_i) begin
          state_d = OWN1;
        end else begin
          state_d = IDLE;
        end
      end
      OWN0: begin
        if (bus.m0_enable_i) begin
          state_d = OWN0;
        end else begin
          state_d = GAP;
          last_d  = 1'b0;
        end
      end
      OWN1: begin
        if (bus.m1_enable_i) begin
          state_d = OWN1;
        end else begin
          state_d = GAP;
          last_d  = 1'b1;
        end
      end
      GAP: begin
        // Requests seen here are picked up from IDLE on the next edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        last_d  = 1'b1;
      end
    endcase
  end

  // Ack accounting: count acks per owner, flag acks that have no owner.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    err_d  = err_q;
    if (bus.mem_ack_i) begin
      case (state_q)
        OWN0:    cnt0_d = cnt0_q + CNT_W'(1);
        OWN1:    cnt1_d = cnt1_q + CNT_W'(1);
        IDLE:    err_d  = 1'b1;
        GAP:     err_d  = 1'b1;
        default: err_d  = 1'b1;
      endcase
    end else begin
      cnt0_d = cnt0_q;
      cnt1_d = cnt1_q;
      err_d  = err_q;
    end
  end

  // Request/response steering: the owner's inputs pass straight to memory and
  // the memory response passes straight back to the owner in the same cycle.
  // Reset forces IDLE asynchronously, so everything reads 0 while rst_i is low.
  always_comb begin
    bus.mem_enable_o = 1'b0;
    bus.mem_write_o  = 1'b0;
    bus.mem_addr_o   = 32'h0000_0000;
    bus.mem_data_o   = '0;
    bus.m0_ack_o     = 1'b0;
    bus.m1_ack_o     = 1'b0;
    bus.m0_data_o    = '0;
    bus.m1_data_o    = '0;
    case (state_q)
      OWN0: begin
        bus.mem_enable_o = bus.m0_enable_i;
        bus.mem_write_o  = bus.m0_write_i;
        bus.mem_addr_o   = bus.m0_addr_i;
        bus.mem_data_o   = bus.m0_data_i;
        bus.m0_ack_o     = bus.mem_ack_i;
        bus.m0_data_o    = bus.mem_data_i;
      end
      OWN1: begin
        bus.mem_enable_o = bus.m1_enable_i;
        bus.mem_write_o  = bus.m1_write_i;
        bus.mem_addr_o   = bus.m1_addr_i;
        bus.mem_data_o   = bus.m1_data_i;
        bus.m1_ack_o     = bus.mem_ack_i;
        bus.m1_data_o    = bus.mem_data_i;
      end
      default: begin
        bus.mem_enable_o = 1'b0;
        bus.m0_ack_o     = 1'b0;
        bus.m1_ack_o     = 1'b0;
      end
    endcase
  end

  assign ack_cnt0_o = cnt0_q;
  assign ack_cnt1_o = cnt1_q;
  assign err_o      = err_q;

endmodule
